// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
//   GROUP_W      : width of one lookahead group (4 bits)
//   group_gp_t   : per-bit generate/propagate vectors of one group
//   group_gp()   : builds G = A & B and P = A | B for one group
package cla_pkg;

  localparam int GROUP_W = 4;

  typedef struct packed {
    logic [GROUP_W-1:0] g;
    logic [GROUP_W-1:0] p;
  } group_gp_t;

  function automatic group_gp_t group_gp(input logic [GROUP_W-1:0] a,
                                         input logic [GROUP_W-1:0] b);
    group_gp_t r;
    r.g = a & b;
    r.p = a | b;
    return r;
  endfunction

endpackage

// File: rtl/cla4_group.sv
// Combinational 4-bit carry-lookahead slice.
//   i_a, i_b : group operands (B already inverted for subtraction)
//   i_cin    : carry into bit 0 of the group
//   o_sum    : 4-bit sum
//   o_pg     : group propagate (a carry entering the group leaves it)
//   o_gg     : group generate (the group produces a carry on its own)
module cla4_group
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] i_a,
  input  logic [GROUP_W-1:0] i_b,
  input  logic               i_cin,
  output logic [GROUP_W-1:0] o_sum,
  output logic               o_pg,
  output logic               o_gg
);

  group_gp_t          w_gp;
  logic [GROUP_W-1:0] w_c;

  assign w_gp = group_gp(i_a, i_b);

  // Flat two-level carry equations; no bit depends on a neighbour's carry.
  assign w_c[0] = i_cin;
  assign w_c[1] = w_gp.g[0] | (w_gp.p[0] & i_cin);
  assign w_c[2] = w_gp.g[1] | (w_gp.p[1] & w_gp.g[0])
                | (w_gp.p[1] & w_gp.p[0] & i_cin);
  assign w_c[3] = w_gp.g[2] | (w_gp.p[2] & w_gp.g[1])
                | (w_gp.p[2] & w_gp.p[1] & w_gp.g[0])
                | (w_gp.p[2] & w_gp.p[1] & w_gp.p[0] & i_cin);

  // P is the OR form, so the sum needs the true half-sum a ^ b.
  assign o_sum = i_a ^ i_b ^ w_c;
  assign o_pg  = &w_gp.p;
  assign o_gg  = w_gp.g[3] | (w_gp.p[3] & w_gp.g[2])
               | (w_gp.p[3] & w_gp.p[2] & w_gp.g[1])
               | (w_gp.p[3] & w_gp.p[2] & w_gp.p[1] & w_gp.g[0]);

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready streams.
// Each of L = WIDTH/(4*GPS) stages resolves GPS lookahead groups and hands
// its carry to the next stage; untouched operand bits travel with the beat.
//   Clk, Reset           : clock, synchronous active-high reset
//   in_valid/in_ready    : operand beat handshake
//   in_a, in_b           : operands
//   in_cin               : carry in (add only), in_sub: 1 = A - B
//   out_valid/out_ready  : result beat handshake
//   out_sum, out_cout    : result and carry out (sub: 1 = no borrow)
//   out_ovf, out_zero    : signed overflow, result is zero
// Handshake: a beat moves when valid && ready on the same rising edge.
// While out_valid && !out_ready the whole pipeline holds and out_* are
// stable; in_ready is the global advance signal.
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GPS   = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int SW = GROUP_W * GPS;  // bits resolved per stage
  localparam int L  = WIDTH / SW;     // pipeline depth

  // cmsb is the carry into this stage's top bit; only the last stage's
  // copy is used, for overflow detection.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             cmsb;
  } stage_t;

  stage_t r_st  [L];
  stage_t w_nxt [L];
  logic   w_advance;

  assign w_advance = !r_st[L-1].valid || out_ready;
  assign in_ready  = w_advance;

  for (genvar k = 0; k < L; k++) begin : g_stage
    stage_t           w_src;
    stage_t           w_out;
    logic [GPS-1:0]   w_pg;
    logic [GPS-1:0]   w_gg;
    logic [GPS:0]     w_c;
    logic [SW-1:0]    w_sum;

    if (k == 0) begin : g_first
      // Subtraction is A + ~B + 1; cin only matters when adding.
      always_comb begin
        w_src       = '0;
        w_src.valid = in_valid;
        w_src.a     = in_a;
        w_src.b     = in_sub ? ~in_b : in_b;
        w_src.carry = in_sub | in_cin;
      end
    end else begin : g_rest
      assign w_src = r_st[k-1];
    end

    for (genvar j = 0; j < GPS; j++) begin : g_grp
      cla4_group u_grp (
        .i_a   (w_src.a[SW*k + GROUP_W*j +: GROUP_W]),
        .i_b   (w_src.b[SW*k + GROUP_W*j +: GROUP_W]),
        .i_cin (w_c[j]),
        .o_sum (w_sum[GROUP_W*j +: GROUP_W]),
        .o_pg  (w_pg[j]),
        .o_gg  (w_gg[j])
      );
    end

    // Second-level lookahead: each group carry is a sum of products of
    // group generates/propagates and the stage carry-in, so carries do not
    // ripple from group to group inside a stage.
    always_comb begin
      logic v_acc;
      logic v_prod;
      v_acc  = 1'b0;
      v_prod = 1'b0;
      w_c    = '0;
      w_c[0] = w_src.carry;
      for (int j = 1; j <= GPS; j++) begin
        v_acc = 1'b0;
        for (int i = 0; i < j; i++) begin
          v_prod = w_gg[i];
          for (int m = i + 1; m < j; m++) v_prod = v_prod & w_pg[m];
          v_acc = v_acc | v_prod;
        end
        v_prod = w_src.carry;
        for (int m = 0; m < j; m++) v_prod = v_prod & w_pg[m];
        w_c[j] = v_acc | v_prod;
      end
    end

    // Carry into the top bit recovered from sum = a ^ b ^ c at that bit.
    always_comb begin
      w_out                  = w_src;
      w_out.sum[SW*k +: SW]  = w_sum;
      w_out.carry            = w_c[GPS];
      w_out.cmsb             = w_sum[SW-1] ^ w_src.a[SW*(k+1)-1]
                             ^ w_src.b[SW*(k+1)-1];
    end

    assign w_nxt[k] = w_out;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < L; i++) r_st[i] <= '0;
    end else if (w_advance) begin
      for (int i = 0; i < L; i++) r_st[i] <= w_nxt[i];
    end
  end

  assign out_valid = r_st[L-1].valid;
  assign out_sum   = r_st[L-1].sum;
  assign out_cout  = r_st[L-1].carry;
  assign out_ovf   = r_st[L-1].cmsb ^ r_st[L-1].carry;
  // Gated so the idle/reset state reports zero=0.
  assign out_zero  = r_st[L-1].valid & ~|r_st[L-1].sum;

endmodule
